// File: rtl/e2bcd_linebuf.sv
// -----------------------------------------------------------------------------
// e2bcd_linebuf
//   EBCDIC -> chain-BCD translator and print-line buffer for the AN-chain path.
//   Bytes of one print line are translated through a one-cycle registered stage
//   and written into a LINE_LEN-entry buffer.  The unused tail is padded with
//   blanks, then the line is held for random-access reads by the chain-scan
//   logic until the printer releases it.
//
//   Build option: define E2BCD_UNASG_SUB_EN to store unassigned bytes as a
//   printable SUB_CODE (lozenge).  Left undefined, they are stored as blanks.
//
// Ports
//   i_clk        clock
//   i_reset_n    asynchronous active-low reset
//   i_valid      input byte valid
//   o_ready      block accepts a byte (transfer = i_valid & o_ready)
//   i_data       EBCDIC byte
//   i_last       byte is the last one of the line
//   o_line_rdy   line complete and padded; read port contents valid
//   i_release    one-cycle pulse: printer is done with the held line
//   i_rd_addr    print position to read
//   o_rd_bcd     {B,A,8,4,2,1} at i_rd_addr, one-cycle latency
//   o_rd_print   position holds a printable graphic, one-cycle latency
//   o_unasg_cnt  unassigned bytes seen in the current line, saturating
// -----------------------------------------------------------------------------
module e2bcd_linebuf #(
  parameter int          LINE_LEN = 132,
  parameter int          AW       = 8,
  parameter logic [5:0]  SUB_CODE = 6'o74
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [7:0]    i_data,
  input  logic          i_last,
  output logic          o_line_rdy,
  input  logic          i_release,
  input  logic [AW-1:0] i_rd_addr,
  output logic [5:0]    o_rd_bcd,
  output logic          o_rd_print,
  output logic [AW:0]   o_unasg_cnt
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LAST_POS  = AW'(LINE_LEN - 1);
  localparam logic [AW:0]   UNASG_MAX = {(AW+1){1'b1}};

  // Entry stored for an unassigned byte.  Without the substitute option it is
  // a blank; SUB_CODE is masked off in that build.
`ifdef E2BCD_UNASG_SUB_EN
  localparam logic [6:0] UNASG_ENTRY = {1'b1, SUB_CODE};
`else
  localparam logic [6:0] UNASG_ENTRY = {1'b0, SUB_CODE & 6'o00};
`endif

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  col_reg, col_next;
  logic [AW:0]    unasg_cnt_reg, unasg_cnt_next;

  // Translate stage: holds one translated byte until its buffer write
  logic           tr_valid_reg;
  logic [AW-1:0]  tr_addr_reg;
  logic [6:0]     tr_entry_reg;

  logic [6:0]     rd_data_reg;
  logic [6:0]     mem [0:DEPTH-1];

  logic           xfer;
  logic           pad_wr;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [6:0]     wr_data;

  // ---------------------------------------------------------------------------
  // Translation of the incoming byte
  // ---------------------------------------------------------------------------
  logic           lo_digit;
  logic [7:0]     fold_byte;
  logic [3:0]     f_hi;
  logic [3:0]     f_lo;
  logic           xl_print;
  logic           xl_unasg;
  logic [5:0]     xl_bcd;
  logic [6:0]     xl_entry;

  always_comb begin
    lo_digit  = (i_data[3:0] >= 4'd1) && (i_data[3:0] <= 4'd9);
    // Lower-case letters live at 8x/9x/Ax; setting bit 6 moves them to Cx/Dx/Ex.
    fold_byte = i_data;
    if (lo_digit && (i_data[7:4] == 4'h8 || i_data[7:4] == 4'h9 || i_data[7:4] == 4'hA)) begin
      fold_byte = {i_data[7], 1'b1, i_data[5:0]};
    end
    f_hi     = fold_byte[7:4];
    f_lo     = fold_byte[3:0];
    xl_print = 1'b1;
    xl_unasg = 1'b0;
    xl_bcd   = 6'd0;

    if (i_data[5:0] == 6'd0) begin
      // 00/40/80/C0 are all treated as a space
      xl_print = 1'b0;
    end else if (lo_digit && f_hi == 4'hF) begin
      xl_bcd = {2'b00, f_lo};                 // 1-9
    end else if (lo_digit && f_hi == 4'hE && f_lo != 4'd1) begin
      xl_bcd = {2'b01, f_lo};                 // S-Z
    end else if (lo_digit && f_hi == 4'hD) begin
      xl_bcd = {2'b10, f_lo};                 // J-R
    end else if (lo_digit && f_hi == 4'hC) begin
      xl_bcd = {2'b11, f_lo};                 // A-I
    end else begin
      case (fold_byte)
        8'hF0:        xl_bcd = 6'b001010;     // 0
        8'h7B, 8'h7E: xl_bcd = 6'b001011;     // # =
        8'h7C, 8'h7D: xl_bcd = 6'b001100;     // @ '
        8'h61:        xl_bcd = 6'b010001;     // /
        8'h50:        xl_bcd = 6'b011010;     // &
        8'h6B:        xl_bcd = 6'b011011;     // ,
        8'h6C, 8'h4D: xl_bcd = 6'b011100;     // % (
        8'h60:        xl_bcd = 6'b101010;     // -
        8'h5B:        xl_bcd = 6'b101011;     // $
        8'h5C:        xl_bcd = 6'b101100;     // *
        8'h4E:        xl_bcd = 6'b111010;     // +
        8'h4B:        xl_bcd = 6'b111011;     // .
        8'h4C, 8'h5D: xl_bcd = 6'b111100;     // < )
        default: begin
          xl_print = 1'b0;
          xl_unasg = 1'b1;
        end
      endcase
    end

    xl_entry = xl_unasg ? UNASG_ENTRY : {xl_print, xl_bcd};
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    unasg_cnt_next = unasg_cnt_reg;
    o_ready        = 1'b0;
    o_line_rdy     = 1'b0;
    xfer           = 1'b0;
    // The pending translate write owns the single write port; padding waits.
    pad_wr         = 1'b0;

    case (state_reg)
      ST_FILL: begin
        o_ready = 1'b1;
        xfer    = i_valid;
        if (i_valid) begin
          if (xl_unasg && unasg_cnt_reg != UNASG_MAX) begin
            unasg_cnt_next = unasg_cnt_reg + (AW+1)'(1);
          end
          if (col_reg == LAST_POS) begin
            // Full line: nothing to pad, and col stays in range.
            state_next = ST_HOLD;
          end else begin
            col_next = col_reg + AW'(1);
            if (i_last) begin
              state_next = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        pad_wr = !tr_valid_reg;
        if (pad_wr) begin
          if (col_reg == LAST_POS) begin
            state_next = ST_HOLD;
          end else begin
            col_next = col_reg + AW'(1);
          end
        end
      end

      ST_HOLD: begin
        o_line_rdy = 1'b1;
        if (i_release) begin
          state_next     = ST_FILL;
          col_next       = '0;
          unasg_cnt_next = '0;
        end
      end

      default: begin
        state_next = ST_FILL;
        col_next   = '0;
      end
    endcase
  end

  always_comb begin
    wr_en   = tr_valid_reg | pad_wr;
    wr_addr = tr_valid_reg ? tr_addr_reg  : col_reg;
    wr_data = tr_valid_reg ? tr_entry_reg : 7'd0;
  end

  // ---------------------------------------------------------------------------
  // State, translate stage and registered read
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= ST_FILL;
      col_reg       <= '0;
      unasg_cnt_reg <= '0;
      tr_valid_reg  <= 1'b0;
      tr_addr_reg   <= '0;
      tr_entry_reg  <= '0;
      rd_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      unasg_cnt_reg <= unasg_cnt_next;
      tr_valid_reg  <= xfer;
      tr_addr_reg   <= col_reg;
      tr_entry_reg  <= xl_entry;
      // Forward a same-cycle write so the last byte of a full line is visible
      // on the first HOLD cycle.
      if (wr_en && wr_addr == i_rd_addr) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[i_rd_addr];
      end
    end
  end

  // Buffer storage is never cleared; only the write port lives here.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign o_rd_print  = rd_data_reg[6];
  assign o_rd_bcd    = rd_data_reg[5:0];
  assign o_unasg_cnt = unasg_cnt_reg;

endmodule

// File: tb/tb_e2bcd_linebuf.sv
// -----------------------------------------------------------------------------
// tb_e2bcd_linebuf
//   Self-checking bench for e2bcd_linebuf.  Lines are sent through the byte
//   port while a character-table model builds the expected line image; reads
//   push their expected entry into a scoreboard queue and the entry is popped
//   and compared when the registered read data appears.
// -----------------------------------------------------------------------------
module tb_e2bcd_linebuf;

  localparam int LINE_LEN = 132;
  localparam int AW       = 8;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_valid;
  logic          o_ready;
  logic [7:0]    i_data;
  logic          i_last;
  logic          o_line_rdy;
  logic          i_release;
  logic [AW-1:0] i_rd_addr;
  logic [5:0]    o_rd_bcd;
  logic          o_rd_print;
  logic [AW:0]   o_unasg_cnt;

  e2bcd_linebuf #(.LINE_LEN(LINE_LEN), .AW(AW), .SUB_CODE(6'o74)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_line_rdy  (o_line_rdy),
    .i_release   (i_release),
    .i_rd_addr   (i_rd_addr),
    .o_rd_bcd    (o_rd_bcd),
    .o_rd_print  (o_rd_print),
    .o_unasg_cnt (o_unasg_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [6:0] sb_q [$];
  logic [6:0] exp_line [LINE_LEN];
  int         exp_pos;
  int         exp_unasg;
  int         line_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: character rows in column order 1..12, B/A row = table row.
  function automatic logic [6:0] model_entry(input logic [7:0] b_in, output bit unasg);
    logic [7:0] tbl [4][12];
    logic [7:0] b;
    tbl[0] = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'hF9, 8'hF0, 8'h7B, 8'h7C};
    tbl[1] = '{8'h61, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8, 8'hE9, 8'h50, 8'h6B, 8'h6C};
    tbl[2] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hD8, 8'hD9, 8'h60, 8'h5B, 8'h5C};
    tbl[3] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'h4E, 8'h4B, 8'h4C};
    unasg = 1'b0;
    b = b_in;
    if ((b >= 8'h81 && b <= 8'h89) || (b >= 8'h91 && b <= 8'h99) || (b >= 8'hA2 && b <= 8'hA9))
      b = b + 8'h40;
    if (b == 8'h7E) b = 8'h7B;
    if (b == 8'h7D) b = 8'h7C;
    if (b == 8'h4D) b = 8'h6C;
    if (b == 8'h5D) b = 8'h4C;
    if (b == 8'h00 || b == 8'h40 || b == 8'h80 || b == 8'hC0) return 7'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 12; c++)
        if (tbl[r][c] == b) return {1'b1, 2'(r), 4'(c + 1)};
    unasg = 1'b1;
`ifdef E2BCD_UNASG_SUB_EN
    return 7'b1111100;
`else
    return 7'd0;
`endif
  endfunction

  task automatic line_start();
    for (int i = 0; i < LINE_LEN; i++) exp_line[i] = 7'd0;
    exp_pos   = 0;
    exp_unasg = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int  n;
    bit  u;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = b;
    i_last  = last;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) check("ready_wait", 32'(o_ready), 32'(1));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (exp_pos < LINE_LEN) exp_line[exp_pos] = model_entry(b, u);
    else                    u = 1'b0;
    exp_pos++;
    if (u && exp_unasg < 511) exp_unasg++;
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!o_line_rdy && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    check("line_rdy", 32'(o_line_rdy), 32'(1));
    line_no++;
    $display("line %0d held: %0d bytes, unassigned %0d", line_no, exp_pos, o_unasg_cnt);
  endtask

  task automatic read_chk(input int addr);
    logic [6:0] e;
    @(negedge i_clk);
    i_rd_addr = AW'(addr);
    sb_q.push_back(exp_line[addr]);
    @(negedge i_clk);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      check($sformatf("pos%0d", addr), 32'({o_rd_print, o_rd_bcd}), 32'(e));
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < LINE_LEN; i++) read_chk(i);
  endtask

  task automatic release_line();
    @(negedge i_clk);
    i_release = 1'b1;
    @(negedge i_clk);
    i_release = 1'b0;
    check("rel_line_rdy", 32'(o_line_rdy), 32'(0));
    check("rel_ready", 32'(o_ready), 32'(1));
    check("rel_unasg", 32'(o_unasg_cnt), 32'(0));
    line_start();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b1;
    i_valid   = 1'b0;
    i_data    = 8'h00;
    i_last    = 1'b0;
    i_release = 1'b0;
    i_rd_addr = '0;
    #1 i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'(1));
    check("rst_line_rdy", 32'(o_line_rdy), 32'(0));
    check("rst_bcd", 32'(o_rd_bcd), 32'(0));
    check("rst_print", 32'(o_rd_print), 32'(0));
    check("rst_unasg", 32'(o_unasg_cnt), 32'(0));
    i_reset_n = 1'b1;
    line_start();

    // Line 1: C1 C2 F0 5B
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h5B, 1'b1);
    wait_hold();
    check("l1_pos0_const", 32'(exp_line[0]), 32'(7'b1110001));
    read_all();

    // Line 2: dual codes and lower-case fold
    release_line();
    send_byte(8'h7B, 1'b0);
    send_byte(8'h7E, 1'b0);
    send_byte(8'h7C, 1'b0);
    send_byte(8'h7D, 1'b0);
    send_byte(8'h81, 1'b1);
    wait_hold();
    for (int i = 0; i < 8; i++) read_chk(i);
    read_chk(LINE_LEN - 1);

    // Line 3: full line, no i_last
    release_line();
    for (int i = 0; i < LINE_LEN; i++) send_byte(8'hF1, 1'b0);
    @(negedge i_clk);
    check("full_ready_low", 32'(o_ready), 32'(0));
    check("full_line_rdy", 32'(o_line_rdy), 32'(1));
    i_valid = 1'b1;
    i_data  = 8'hF2;
    repeat (4) @(negedge i_clk);
    check("extra_not_acc", 32'(o_ready), 32'(0));
    i_valid = 1'b0;
    line_no++;
    $display("line %0d held: %0d bytes, unassigned %0d", line_no, exp_pos, o_unasg_cnt);
    read_all();

    // Line 4: spaces and unassigned bytes
    release_line();
    send_byte(8'h40, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h07, 1'b1);
    wait_hold();
    check("unasg_cnt", 32'(o_unasg_cnt), 32'(exp_unasg));
    check("unasg_cnt2", 32'(o_unasg_cnt), 32'(2));
    for (int i = 0; i < 6; i++) read_chk(i);

    // Line 5: overwrite from pos0, release during FILL ignored
    release_line();
    send_byte(8'hC3, 1'b0);
    @(negedge i_clk);
    i_release = 1'b1;
    @(negedge i_clk);
    i_release = 1'b0;
    send_byte(8'hC4, 1'b1);
    wait_hold();
    for (int i = 0; i < 4; i++) read_chk(i);

    // Line 6: reset mid-fill at col 50
    release_line();
    for (int i = 0; i < 50; i++) send_byte((i % 7 == 3) ? 8'hFF : 8'hC1 + 8'(i % 9), 1'b0);
    @(negedge i_clk);
    check("pre_rst_unasg", 32'(o_unasg_cnt), 32'(exp_unasg));
    i_rd_addr = 8'd0;
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(o_ready), 32'(1));
    check("mid_rst_line_rdy", 32'(o_line_rdy), 32'(0));
    check("mid_rst_bcd", 32'(o_rd_bcd), 32'(0));
    check("mid_rst_print", 32'(o_rd_print), 32'(0));
    check("mid_rst_unasg", 32'(o_unasg_cnt), 32'(0));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    line_start();
    send_byte(8'hD1, 1'b1);
    wait_hold();
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
